// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port: access size codes and the
// byte-lane helpers used on the store and load paths.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Byte lanes touched by an access of the given size at the given row offset.
  function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // True when the offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic r;
    case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = off[0];
      SZ_W:    r = |off[1:0];
      default: r = |off;
    endcase
    return r;
  endfunction

  // Pull the addressed bytes out of a 64-bit row, right-align and extend them.
  function automatic logic [63:0] load_align(input logic [63:0] row, input logic [2:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [63:0] sh;
    logic [63:0] r;
    sh = row >> {off, 3'b000};
    case (size)
      SZ_B:    r = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      SZ_H:    r = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      SZ_W:    r = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_port_rsp_fifo.sv
// Response buffer: a small register FIFO holding {err, rdata}. The head entry
// drives the response outputs directly, so they are registered and hold
// steady while the consumer stalls. Full/empty come from pointers carrying
// an extra wrap bit, which works for any depth.
module rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0]    wr_idx_q, rd_idx_q;
  logic             wr_wrap_q, rd_wrap_q;
  logic             empty;
  logic             do_pop;

  // Advance a pointer, toggling its wrap bit when it rolls over.
  function automatic logic [IW:0] bump(input logic [IW-1:0] idx, input logic wrap);
    if (idx == IW'(DEPTH - 1)) return {~wrap, {IW{1'b0}}};
    return {wrap, IW'(idx + 1'b1)};
  endfunction

  // Empty when both pointers match including wrap; pops only from a non-empty FIFO.
  always_comb begin
    empty   = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
    valid_o = !empty;
    head_o  = mem_q[rd_idx_q];
    do_pop  = pop_i && !empty;
  end

  // Storage and pointer update; a push and pop on a full FIFO share the head slot safely.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_wrap_q <= 1'b0;
    end else begin
      if (push_i) begin
        mem_q[wr_idx_q]         <= push_data_i;
        {wr_wrap_q, wr_idx_q}   <= bump(wr_idx_q, wr_wrap_q);
      end
      if (do_pop) begin
        {rd_wrap_q, rd_idx_q}   <= bump(rd_idx_q, rd_wrap_q);
      end
    end
  end

endmodule

// File: rtl/dmem_port.sv
// Pipelined data-memory port. Requests are checked for alignment and range,
// stores commit on the acceptance edge with byte enables, loads are aligned
// and extended from the row read at acceptance and then travel LAT-1 extra
// register stages into the response FIFO. A credit counter sized to the FIFO
// keeps the pipeline from overflowing and makes req_ready purely registered.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its payload stable until then.
// INIT_FILE is carried for interface compatibility; preloading images is done
// by the memory wrapper of the implementation flow, the array here starts unset.
module dmem_port
  import dmem_pkg::*;
#(
  parameter int    XLEN      = 64,
  parameter int    AW        = 12,
  parameter int    LAT       = 1,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int ROWS = 1 << (AW - 3);
  localparam int CW   = $clog2(LAT + 2);
  localparam int FW   = XLEN + 1;

  logic [XLEN-1:0] mem_q [ROWS];
  logic [CW-1:0]   cred_q, cred_d;

  logic            acc, rsp_hs, err, wr_en;
  logic [2:0]      off;
  logic [AW-4:0]   row;
  logic [7:0]      be;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] row_rd;
  logic [FW-1:0]   s1_data;
  logic            push_v;
  logic [FW-1:0]   push_d;
  logic [FW-1:0]   head;

  // Request decode: error checks, byte lanes, shifted store data and load result.
  always_comb begin
    off       = req_addr[2:0];
    row       = req_addr[AW-1:3];
    err       = misaligned(req_size, off) || (|req_addr[XLEN-1:AW]);
    acc       = req_valid && req_ready && !rst;
    rsp_hs    = rsp_valid && rsp_ready;
    wr_en     = acc && req_we && !err;
    be        = byte_en(req_size, off);
    wdata_sh  = req_wdata << {off, 3'b000};
    row_rd    = mem_q[row];
    s1_data   = {err, (err || req_we) ? {XLEN{1'b0}}
                                      : load_align(row_rd, off, req_size, req_unsigned)};
  end

  // Memory rows with per-byte write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem_q[row][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // LAT-1 extra register stages between the row read and the FIFO.
  if (LAT == 1) begin : g_direct
    assign push_v = acc;
    assign push_d = s1_data;
  end else begin : g_pipe
    logic [LAT-2:0] v_q;
    logic [FW-1:0]  d_q [LAT-1];

    // Shift accepted results toward the response FIFO.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= '0;
        for (int i = 0; i < LAT - 1; i++) d_q[i] <= '0;
      end else begin
        v_q[0] <= acc;
        d_q[0] <= s1_data;
        for (int i = 1; i < LAT - 1; i++) begin
          v_q[i] <= v_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end

    assign push_v = v_q[LAT-2];
    assign push_d = d_q[LAT-2];
  end

  rsp_fifo #(
    .DEPTH (LAT + 1),
    .WIDTH (FW)
  ) u_rsp_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push_v),
    .push_data_i (push_d),
    .pop_i       (rsp_hs),
    .valid_o     (rsp_valid),
    .head_o      (head)
  );

  assign {rsp_err, rsp_rdata} = head;

  // Credits: one per FIFO slot, spent on acceptance, returned on response.
  always_comb begin
    cred_d = cred_q;
    if (acc && !rsp_hs)      cred_d = cred_q - CW'(1);
    else if (!acc && rsp_hs) cred_d = cred_q + CW'(1);
  end

  // Credit register; full credit after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cred_q <= CW'(LAT + 1);
    else     cred_q <= cred_d;
  end

  assign req_ready = (cred_q != '0);

endmodule

// File: tb/tb_dmem_port.sv
// Bench for dmem_port: directed cases plus a randomized run, all responses
// checked against a byte-array model of the memory.
module tb_dmem_port;

  localparam int LAT = 2;
  localparam int MB  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  dmem_port #(
    .XLEN      (64),
    .AW        (12),
    .LAT       (LAT),
    .INIT_FILE ("")
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [MB];

  function automatic logic [64:0] model_access(input logic we, input logic [1:0] size,
                                               input logic uns, input logic [63:0] addr,
                                               input logic [63:0] wdata);
    int n;
    logic [63:0] v;
    n = 1 << size;
    if ((addr % 64'(n)) != 0 || addr >= 64'(MB)) return {1'b1, 64'd0};
    if (we) begin
      for (int k = 0; k < n; k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
      return 65'd0;
    end
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(addr) + k];
    if (!uns && n < 8 && v[8*n-1])
      for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
    return {1'b0, v};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [64:0] exp_q[$];
  int          acc_q[$];
  logic [64:0] last_rsp = '0;
  bit          timing_on = 0;
  bit          prev_stall = 0;
  logic [64:0] prev_head = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("hold_stable", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, prev_head});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 65'd1, 65'd0);
        end else begin
          logic [64:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rsp", {rsp_err, rsp_rdata}, e);
          last_rsp = {rsp_err, rsp_rdata};
          if (timing_on) chk("latency", 65'(cyc - a), 65'(LAT));
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_head  = {rsp_err, rsp_rdata};
      if (req_valid && req_ready) begin
        exp_q.push_back(model_access(req_we, req_size, req_unsigned, req_addr, req_wdata));
        acc_q.push_back(cyc);
      end
    end
  end

  // ---------------- drivers ----------------
  int stall_cnt = 0;

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata);
    int waits;
    bit done;
    waits = 0;
    done  = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    while (!done) begin
      @(negedge clk);
      done = req_ready;
      @(posedge clk); #1;
      if (!done) begin
        waits++;
        stall_cnt++;
        if (waits > 200) begin
          chk("req_timeout", 65'd0, 65'd1);
          done = 1;
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 65'(exp_q.size()), 65'd0);
  endtask

  // ---------------- stimulus ----------------
  bit rand_on = 0;
  int acc_cnt;
  logic [63:0] d;

  initial begin
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;

    // Reset state.
    @(negedge clk);
    chk("rst_req_ready", 65'(req_ready), 65'd1);
    chk("rst_rsp_valid", 65'(rsp_valid), 65'd0);
    chk("rst_rsp_rdata", 65'(rsp_rdata), 65'd0);
    chk("rst_rsp_err",   65'(rsp_err),   65'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill every row so the model knows the whole memory.
    for (int r = 0; r < MB / 8; r++) do_req(1'b1, 2'b11, 1'b0, 64'(r * 8), {$urandom, $urandom});
    drain();

    // Byte store/load with sign and zero extension.
    do_req(1'b1, 2'b00, 1'b0, 64'h013, 64'hA5);
    do_req(1'b0, 2'b00, 1'b0, 64'h013, 64'h0);
    drain();
    chk("byte_signed", last_rsp, {1'b0, 64'hFFFF_FFFF_FFFF_FFA5});
    do_req(1'b0, 2'b00, 1'b1, 64'h013, 64'h0);
    drain();
    chk("byte_unsigned", last_rsp, {1'b0, 64'h0000_0000_0000_00A5});

    // Double store then half and word loads.
    do_req(1'b1, 2'b11, 1'b0, 64'h020, 64'h1122_3344_5566_7788);
    do_req(1'b0, 2'b01, 1'b0, 64'h026, 64'h0);
    drain();
    chk("half_at_26", last_rsp, {1'b0, 64'h0000_0000_0000_1122});
    do_req(1'b0, 2'b10, 1'b0, 64'h024, 64'h0);
    drain();
    chk("word_at_24", last_rsp, {1'b0, 64'h0000_0000_1122_3344});

    // Errors: misaligned load, out-of-range store leaves memory untouched.
    do_req(1'b0, 2'b10, 1'b0, 64'h006, 64'h0);
    drain();
    chk("misaligned", last_rsp, {1'b1, 64'h0});
    do_req(1'b1, 2'b00, 1'b0, 64'h000, 64'h5A);
    do_req(1'b1, 2'b00, 1'b0, 64'h1000, 64'h77);
    drain();
    chk("oor_store", last_rsp, {1'b1, 64'h0});
    do_req(1'b0, 2'b00, 1'b1, 64'h000, 64'h0);
    drain();
    chk("oor_no_write", last_rsp, {1'b0, 64'h5A});

    // Backpressure: only LAT+1 requests fit with the consumer stalled.
    rsp_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0;
      req_addr = 64'(8 * (i + 4)); req_wdata = '0;
      @(negedge clk);
      if (req_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("bp_accepted", 65'(acc_cnt), 65'(LAT + 1));
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_low", 65'(req_ready), 65'd0);
      chk("bp_rsp_pending", 65'(rsp_valid), 65'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("bp_ready_back", 65'(req_ready), 65'd1);
    @(posedge clk); #1;

    // Throughput and read-after-write: back-to-back store/load pairs.
    timing_on = 1;
    stall_cnt = 0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      do_req(1'b1, 2'b11, 1'b0, 64'(64'h100 + 8 * i), d);
      do_req(1'b0, 2'b11, 1'b0, 64'(64'h100 + 8 * i), 64'h0);
    end
    drain();
    timing_on = 0;
    chk("tp_no_stall", 65'(stall_cnt), 65'd0);
    chk("raw_data", last_rsp, {1'b0, d});

    // Reset with responses outstanding.
    rsp_ready = 1'b0;
    do_req(1'b0, 2'b11, 1'b0, 64'h020, 64'h0);
    do_req(1'b0, 2'b01, 1'b0, 64'h026, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", 65'(rsp_valid), 65'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 65'(rsp_valid), 65'd0);
    chk("mid_rst_req_ready", 65'(req_ready), 65'd1);
    chk("mid_rst_rdata",     65'(rsp_rdata), 65'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    do_req(1'b0, 2'b11, 1'b0, 64'h020, 64'h0);
    drain();
    chk("post_rst_data", last_rsp, {1'b0, 64'h1122_3344_5566_7788});

    // Randomized traffic with random consumer stalls.
    rand_on = 1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [1:0]  sz;
          logic [63:0] a;
          sz = 2'($urandom_range(0, 3));
          a  = 64'($urandom_range(0, 511));
          if ($urandom_range(0, 4) != 0) a = a & ~64'((1 << sz) - 1);
          if ($urandom_range(0, 15) == 0) a = a | (64'h1000 << $urandom_range(0, 51));
          do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
          if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
